// File: rtl/tictactoe_pkg.sv
// Shared definitions for the tic-tac-toe input stage: cell indices, cursor
// reset value, command-state encoding and small cursor helpers.
package tictactoe_pkg;

  localparam logic [3:0] CELL_0 = 4'd0;
  localparam logic [3:0] CELL_1 = 4'd1;
  localparam logic [3:0] CELL_2 = 4'd2;
  localparam logic [3:0] CELL_3 = 4'd3;
  localparam logic [3:0] CELL_4 = 4'd4;
  localparam logic [3:0] CELL_5 = 4'd5;
  localparam logic [3:0] CELL_6 = 4'd6;
  localparam logic [3:0] CELL_7 = 4'd7;
  localparam logic [3:0] CELL_8 = 4'd8;

  localparam logic [3:0] CURSOR_RESET = CELL_4;

  localparam int unsigned HOLD_CYCLES_DEFAULT = 16;
  localparam int unsigned GAP_CYCLES          = 2;

  typedef enum logic [2:0] {
    IDLE,
    HOLD_CELL,
    HOLD_ERASE,
    HOLD_RESTART,
    GAP
  } cmd_state_e;

  // One-hot click vector for a cell index; out-of-range indices give no click.
  function automatic logic [8:0] cell_onehot(input logic [3:0] idx);
    logic [8:0] v;
    v = '0;
    unique case (idx)
      CELL_0:  v = 9'b000000001;
      CELL_1:  v = 9'b000000010;
      CELL_2:  v = 9'b000000100;
      CELL_3:  v = 9'b000001000;
      CELL_4:  v = 9'b000010000;
      CELL_5:  v = 9'b000100000;
      CELL_6:  v = 9'b001000000;
      CELL_7:  v = 9'b010000000;
      CELL_8:  v = 9'b100000000;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Step a 0..2 coordinate with wrap; opposing requests cancel.
  function automatic logic [1:0] wrap_step(input logic [1:0] v, input logic inc,
                                           input logic dec);
    logic [1:0] r;
    r = v;
    if (inc && !dec) begin
      r = (v == 2'd2) ? 2'd0 : v + 2'd1;
    end else if (dec && !inc) begin
      r = (v == 2'd0) ? 2'd2 : v - 2'd1;
    end
    return r;
  endfunction

  function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
    return ({2'b00, row} * 4'd3) + {2'b00, col};
  endfunction

endpackage

// File: rtl/cell_selector_if.sv
// Board-side bundle: raw buttons in, game commands and cursor out.
interface cell_selector_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_select;
  logic       btn_erase;
  logic       btn_restart;
  logic [8:0] cuadro;
  logic       erase;
  logic       restart;
  logic [3:0] cursor;
  logic       busy;

  // Board / stimulus side.
  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_select, btn_erase, btn_restart,
    input  cuadro, erase, restart, cursor, busy
  );

  // Input-stage side.
  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_select, btn_erase, btn_restart,
    output cuadro, erase, restart, cursor, busy
  );
endinterface

// File: rtl/button_debouncer.sv
// Synchronizer, stability counter and press-edge pulse for one raw button.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_prev_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has differed from the stable one long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sync2_q == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_q <= sync2_q;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Registered one-cycle pulse on a 0->1 change of the stable level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_prev_q <= 1'b0;
      pulse_q       <= 1'b0;
    end else begin
      stable_prev_q <= stable_q;
      pulse_q       <= stable_q & ~stable_prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/cell_selector.sv
// Tic-tac-toe input stage: debounced buttons drive a 3x3 cursor and a command
// FSM that holds cell clicks, erase and restart long enough for the game FSM.
module cell_selector
  import tictactoe_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEFAULT
) (
  input  logic           clk_100MHz,
  input  logic           reset,
  cell_selector_if.slave bus
);

  localparam int unsigned B_UP      = 0;
  localparam int unsigned B_DOWN    = 1;
  localparam int unsigned B_LEFT    = 2;
  localparam int unsigned B_RIGHT   = 3;
  localparam int unsigned B_SELECT  = 4;
  localparam int unsigned B_ERASE   = 5;
  localparam int unsigned B_RESTART = 6;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

  logic [6:0] raw;
  logic [6:0] pulse;

  assign raw = {bus.btn_restart, bus.btn_erase, bus.btn_select, bus.btn_right,
                bus.btn_left, bus.btn_down, bus.btn_up};

  for (genvar i = 0; i < 7; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk_100MHz),
      .rst  (reset),
      .btn  (raw[i]),
      .pulse(pulse[i])
    );
  end

  cmd_state_e state_q;
  logic [7:0] hold_cnt_q;
  logic [8:0] cuadro_q;
  logic       erase_q, restart_q, busy_q;
  logic [1:0] row_q, col_q, row_d, col_d;
  logic [3:0] cursor_q;
  logic       restart_accept;

  // Restart only counts when the FSM can take it; otherwise only movement applies.
  assign restart_accept = (state_q == IDLE) && pulse[B_RESTART];

  // Next cursor position: restart recentres, otherwise wrap-around moves.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (restart_accept) begin
      row_d = 2'd1;
      col_d = 2'd1;
    end else begin
      row_d = wrap_step(row_q, pulse[B_DOWN], pulse[B_UP]);
      col_d = wrap_step(col_q, pulse[B_RIGHT], pulse[B_LEFT]);
    end
  end

  // Cursor registers; the index output is registered alongside row/col.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      row_q    <= 2'd1;
      col_q    <= 2'd1;
      cursor_q <= CURSOR_RESET;
    end else begin
      row_q    <= row_d;
      col_q    <= col_d;
      cursor_q <= cell_index(row_d, col_d);
    end
  end

  // Command FSM with registered outputs; pulses outside IDLE are dropped.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      cuadro_q   <= '0;
      erase_q    <= 1'b0;
      restart_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          hold_cnt_q <= '0;
          if (pulse[B_RESTART]) begin
            state_q   <= HOLD_RESTART;
            restart_q <= 1'b1;
            busy_q    <= 1'b1;
          end else if (pulse[B_ERASE]) begin
            state_q <= HOLD_ERASE;
            erase_q <= 1'b1;
            busy_q  <= 1'b1;
          end else if (pulse[B_SELECT]) begin
            // Capture the pre-movement cursor.
            state_q  <= HOLD_CELL;
            cuadro_q <= cell_onehot(cursor_q);
            busy_q   <= 1'b1;
          end
        end
        HOLD_CELL, HOLD_ERASE, HOLD_RESTART: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q    <= GAP;
            hold_cnt_q <= '0;
            cuadro_q   <= '0;
            erase_q    <= 1'b0;
            restart_q  <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        GAP: begin
          if (hold_cnt_q == GAP_LAST) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            busy_q     <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q    <= IDLE;
          hold_cnt_q <= '0;
          cuadro_q   <= '0;
          erase_q    <= 1'b0;
          restart_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cuadro  = cuadro_q;
  assign bus.erase   = erase_q;
  assign bus.restart = restart_q;
  assign bus.cursor  = cursor_q;
  assign bus.busy    = busy_q;

endmodule
